jump_scheduler: RTL and testbench

Buffers player jump requests and issues them to the game datapath one at a time. It sits between `keyboard` and the `blocks`/`character` pair and drives their `jump_left`/`jump_right` inputs. A new jump is released only after the previous one has landed or timed out. Queued requests are flushed on a failed jump or when the block is disabled.

---
 rtl/jump_scheduler_pkg.sv | 17 +
 rtl/jump_fifo.sv | 59 +++++
 rtl/jump_scheduler.sv | 122 ++++++++++++
 tb/tb_jump_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jump_scheduler_pkg.sv
// Shared encodings for the jump scheduler: keyboard key codes and FSM states.
package jump_scheduler_pkg;

  localparam logic [1:0] KEY_NONE  = 2'b00;
  localparam logic [1:0] KEY_LEFT  = 2'b01;
  localparam logic [1:0] KEY_RIGHT = 2'b10;
  localparam logic [1:0] KEY_UP    = 2'b11;

  localparam int unsigned AIR_W = 12;

  typedef enum logic [1:0] {
    JS_IDLE     = 2'd0,
    JS_AIRBORNE = 2'd1,
    JS_FAILED   = 2'd2
  } js_state_e;

endpackage

// File: rtl/jump_fifo.sv
// Small FIFO of 1-bit jump directions (0 = left, 1 = right).
// A push while full is accepted only when a pop happens in the same cycle.
module jump_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   din,
  output logic                   dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/jump_scheduler.sv
// Queues left/right jump requests and releases them one at a time, waiting
// for a landing, a failure or an airborne timeout between jumps.
module jump_scheduler
  import jump_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_AIR_MS = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   module_en,
  input  logic [1:0]             key_code,
  input  logic                   one_ms_tick,
  input  logic                   landed,
  input  logic                   jump_fail,
  output logic                   jump_left,
  output logic                   jump_right,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   overflow,
  output logic                   timeout
);

  localparam logic [AIR_W-1:0] AIR_MAX = AIR_W'(MAX_AIR_MS);

  js_state_e        state, next_state;
  logic [1:0]       key_q;
  logic [AIR_W-1:0] air_cnt, air_next, air_inc;
  logic             request;
  logic             push, pop, flush;
  logic             fifo_dout, fifo_full, fifo_empty;
  logic             left_d, right_d, timeout_d, overflow_d;

  assign request = ((key_code == KEY_LEFT) || (key_code == KEY_RIGHT)) &&
                   (key_q == KEY_NONE);
  assign air_inc = (one_ms_tick && (air_cnt != '1)) ? air_cnt + 1'b1 : air_cnt;
  assign busy    = (state == JS_AIRBORNE);

  jump_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (key_code == KEY_RIGHT),
    .dout  (fifo_dout),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= JS_IDLE;
    else      state <= next_state;
  end

  // Next state, queue control and next values of the registered pulses.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    flush      = 1'b0;
    left_d     = 1'b0;
    right_d    = 1'b0;
    timeout_d  = 1'b0;
    air_next   = air_cnt;
    if (!module_en) begin
      next_state = JS_IDLE;
      flush      = 1'b1;
      air_next   = '0;
    end else begin
      case (state)
        JS_IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            left_d     = !fifo_dout;
            right_d    = fifo_dout;
            air_next   = '0;
            next_state = JS_AIRBORNE;
          end
        end
        JS_AIRBORNE: begin
          air_next = air_inc;
          if (jump_fail) begin
            next_state = JS_FAILED;
            flush      = 1'b1;
          end else if (landed) begin
            next_state = JS_IDLE;
          end else if (air_inc >= AIR_MAX) begin
            timeout_d  = 1'b1;
            next_state = JS_IDLE;
          end
        end
        JS_FAILED: flush = 1'b1;
        default:   next_state = JS_IDLE;
      endcase
    end
    // A flushing cycle takes no new request, which also covers disable and FAILED.
    push       = request && !flush;
    overflow_d = push && fifo_full && !pop;
  end

  // Key history, air counter and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q      <= KEY_NONE;
      air_cnt    <= '0;
      jump_left  <= 1'b0;
      jump_right <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      key_q      <= key_code;
      air_cnt    <= air_next;
      jump_left  <= left_d;
      jump_right <= right_d;
      overflow   <= overflow_d;
      timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_jump_scheduler.sv
module tb_jump_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       module_en;
  logic [1:0] key_code;
  logic       one_ms_tick;
  logic       landed;
  logic       jump_fail;
  logic       jump_left;
  logic       jump_right;
  logic       busy;
  logic [2:0] queue_count;
  logic       overflow;
  logic       timeout;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          sb[$];

  jump_scheduler #(.DEPTH(4), .MAX_AIR_MS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (module_en),
    .key_code    (key_code),
    .one_ms_tick (one_ms_tick),
    .landed      (landed),
    .jump_fail   (jump_fail),
    .jump_left   (jump_left),
    .jump_right  (jump_right),
    .busy        (busy),
    .queue_count (queue_count),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One key press of the given direction followed by release.
  task automatic press(input logic [1:0] k);
    key_code = k;
    step();
    key_code = 2'b00;
    step();
  endtask

  // Scoreboard: every jump pulse must match the oldest expected direction.
  always @(negedge clk) begin
    if (jump_left || jump_right) begin
      chk("jump_exclusive", {31'd0, jump_left && jump_right}, 32'd0);
      if (sb.size() == 0) begin
        chk("jump_unexpected", 32'd1, 32'd0);
      end else begin
        chk("jump_dir", {31'd0, jump_right}, {31'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b0; module_en = 1'b0; key_code = 2'b00;
    one_ms_tick = 1'b0; landed = 1'b0; jump_fail = 1'b0;
    step(); step();
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_outs", {27'd0, jump_left, jump_right, busy, overflow, timeout}, 32'd0);
    rst = 1'b1;
    module_en = 1'b1;
    step();

    // Single left press held for 5 cycles.
    key_code = 2'b01; sb.push_back(1'b0);
    step();
    chk("t1_count_after_e0", 32'(queue_count), 32'd1);
    chk("t1_no_pulse_yet", 32'(jump_left), 32'd0);
    step();
    chk("t1_jump_left", 32'(jump_left), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_count_popped", 32'(queue_count), 32'd0);
    step();
    chk("t1_single_pulse", 32'(jump_left), 32'd0);
    step(); step();
    chk("t1_no_second_push", 32'(queue_count), 32'd0);
    key_code = 2'b00;
    step();

    // Queue R, L, R while airborne, then land three times.
    press(2'b10); sb.push_back(1'b1);
    press(2'b01); sb.push_back(1'b0);
    press(2'b10); sb.push_back(1'b1);
    chk("t2_count3", 32'(queue_count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      landed = 1'b1;
      step();
      landed = 1'b0;
      chk("t2_idle_after_land", 32'(busy), 32'd0);
      chk("t2_no_pulse_at_land", {30'd0, jump_left, jump_right}, 32'd0);
      step();
      chk("t2_jump_after_land", 32'(jump_left || jump_right), 32'd1);
      chk("t2_busy_again", 32'(busy), 32'd1);
      chk("t2_count_dec", 32'(queue_count), 32'(2 - i));
    end

    // Five requests while airborne: the fifth overflows.
    begin
      logic [4:0] dirs;
      dirs = 5'b11001;
      for (int i = 0; i < 5; i++) begin
        key_code = dirs[i] ? 2'b10 : 2'b01;
        step();
        key_code = 2'b00;
        chk("t3_overflow", 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
        if (i < 4) sb.push_back(dirs[i]);
        step();
        chk("t3_overflow_pulse_end", 32'(overflow), 32'd0);
      end
    end
    chk("t3_count_full", 32'(queue_count), 32'd4);
    // Land, then push on the same edge as the pop while full.
    landed = 1'b1;
    step();
    landed = 1'b0;
    key_code = 2'b10; sb.push_back(1'b1);
    step();
    key_code = 2'b00;
    chk("t3_full_pushpop_count", 32'(queue_count), 32'd4);
    chk("t3_full_pushpop_no_ovf", 32'(overflow), 32'd0);
    chk("t3_full_pushpop_jump", 32'(jump_left || jump_right), 32'd1);
    step();

    // Airborne timeout after three ticks.
    for (int i = 0; i < 3; i++) begin
      one_ms_tick = 1'b1;
      step();
      one_ms_tick = 1'b0;
      chk("t4_timeout", 32'(timeout), (i == 2) ? 32'd1 : 32'd0);
      if (i == 2) begin
        chk("t4_idle", 32'(busy), 32'd0);
        step();
        chk("t4_timeout_single", 32'(timeout), 32'd0);
        chk("t4_next_jump", 32'(jump_left || jump_right), 32'd1);
        chk("t4_count", 32'(queue_count), 32'd3);
      end else begin
        step();
      end
    end

    // Land once to leave two queued, then fail and land together.
    landed = 1'b1;
    step();
    landed = 1'b0;
    step();
    chk("t5_count2", 32'(queue_count), 32'd2);
    jump_fail = 1'b1; landed = 1'b1;
    step();
    jump_fail = 1'b0; landed = 1'b0;
    sb.delete();
    chk("t5_flushed", 32'(queue_count), 32'd0);
    chk("t5_not_busy", 32'(busy), 32'd0);
    press(2'b01);
    step();
    chk("t5_failed_ignores_keys", 32'(queue_count), 32'd0);
    chk("t5_failed_no_jump", {30'd0, jump_left, jump_right}, 32'd0);
    module_en = 1'b0;
    step();
    module_en = 1'b1;
    key_code = 2'b01; sb.push_back(1'b0);
    step();
    key_code = 2'b00;
    chk("t5_idle_accepts", 32'(queue_count), 32'd1);
    step();
    chk("t5_idle_jumps", 32'(jump_left), 32'd1);

    // Asynchronous reset mid-flight with three queued.
    press(2'b10);
    press(2'b01);
    press(2'b10);
    chk("t6_count3", 32'(queue_count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_count", 32'(queue_count), 32'd0);
    chk("t6_async_outs", {27'd0, jump_left, jump_right, busy, overflow, timeout}, 32'd0);
    step();
    rst = 1'b1;
    step(); step();
    chk("t6_empty_after", 32'(queue_count), 32'd0);
    chk("t6_idle_after", {29'd0, jump_left, jump_right, busy}, 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
